pcie_wr_commit_tracker: RTL and testbench
=========================================

# pcie_wr_commit_tracker

AFU-side consumer of the locally generated commit stream. Watches the AFU TX request stream for writes and DM interrupts that request a commit, and counts outstanding writes. Retires each write when its commit completion arrives, and pulses a per-vector acknowledge for interrupt commits. Provides a write fence: new requests are held until every earlier committed write has been acknowledged. Sits between the AFU TX port and the PF/VF MUX tree, with the commit stream returned from the MUX.

## Interface
- TDATA_WIDTH, ofs_pcie_ss_cfg_pkg::TDATA_WIDTH: TX and commit data width.
- TUSER_WIDTH, ofs_pcie_ss_cfg_pkg::TUSER_WIDTH: tuser_vendor width.
- TUSER_STORE_COMMIT_REQ_BIT, ofs_pcie_ss_cfg_pkg::TUSER_STORE_COMMIT_REQ_BIT: tuser_vendor bit that requests a commit. 0 disables all tracking.
- CNT_WIDTH, 10: outstanding counter width. Maximum outstanding is 2^CNT_WIDTH-1.
- NUM_INTR, 4: number of interrupt vectors acknowledged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- afu_tx_tvalid/tready/tdata/tkeep/tlast/tuser_vendor  in/out/in/in/in/in  1/1/TDATA_WIDTH/TDATA_WIDTH/8/1/TUSER_WIDTH  AFU request stream (sink)
- fim_tx_tvalid/tready/tdata/tkeep/tlast/tuser_vendor  out/in/out/out/out/out  same widths  forwarded request stream (source)
- commit_tvalid  in  1  commit completion valid
- commit_tready  out  1  tied to 1; commits are never stalled
- commit_tdata  in  TDATA_WIDTH  PCIe_CplHdr_t in the low bits
- commit_tuser_vendor  in  TUSER_WIDTH  ignored
- fence_req  in  1  level; request a write fence
- fence_busy  out  1  fence in progress
- fence_done  out  1  one-cycle pulse when the fence completes
- outstanding  out  CNT_WIDTH  registered count of uncommitted writes
- intr_ack  out  NUM_INTR  one-cycle pulse per acknowledged vector
- err_underflow  out  1  sticky error: a write commit arrived with outstanding==0

## Operation
- **SOP tracking.** Register sop is set on reset. On each accepted beat, sop <= tlast.
- **Header classification (sop beats only).**
  - Encoding is DM when func_hdr_is_dm_mode(tuser_vendor) is true.
  - wr = func_is_mwr_req(fmt_type).
  - intr = DM && func_is_interrupt_req(fmt_type).
  - Both require tuser_vendor[TUSER_STORE_COMMIT_REQ_BIT]=1.
  - Only wr headers are counted.
- **Pass-through.** fim_tx_* = afu_tx_* with no modification.
  - fim_tx_tvalid = afu_tx_tvalid && allow.
  - afu_tx_tready = fim_tx_tready && allow.
  - allow = 0 only on an sop beat when either of these holds:
    - fence state is not IDLE, or fence_req=1;
    - the beat is a counted wr and outstanding == max.
- **Counter.**
  - Increment on an accepted counted wr header.
  - Decrement on commit_tvalid with fmt_type == CPL and TC[0]==0.
  - Increment and decrement in the same cycle: no change.
  - Decrement at 0: counter holds 0 and err_underflow is set. It clears only on rst.
- **Interrupt acknowledge.** A commit with TC[0]==1 pulses intr_ack[metadata_l] the next cycle, only when metadata_l < NUM_INTR. Interrupt commits never touch the counter.
- **Fence FSM.**
  - IDLE: on fence_req=1, go to WAIT_EOP if sop==0, otherwise go to DRAIN.
  - WAIT_EOP: go to DRAIN on the accepted tlast beat.
  - DRAIN: when outstanding==0, fence_done=1 for that cycle and go to IDLE.
  - fence_busy = (state != IDLE).
  - fence_req must drop before fence_done + 1. If it is still high, a new fence starts immediately.

## Timing
- **Reset values.**
  - outstanding=0, state IDLE, sop=1.
  - fence_busy=0, fence_done=0, intr_ack=0, err_underflow=0, commit_tready=1.
  - fim_tx_tvalid follows afu_tx_tvalid (combinational).
- **Latency.**
  - The TX path is combinational: 0 cycles.
  - outstanding updates 1 cycle after the handshake or commit.
  - intr_ack is registered: 1 cycle after the commit.
- **fence_done.**
  - It is combinational from the registered state and count. It asserts in the first DRAIN cycle where outstanding==0.
  - Entering DRAIN with outstanding==0 yields fence_done on the very next cycle after fence_req is sampled in IDLE.
- **Hold-off points.** The fence and saturation hold-offs apply at packet boundaries only. A packet in flight always completes.
- **Reset mid-operation.** All state returns to reset values. A partially forwarded packet is the upstream's responsibility.

## Test plan
- **Counting.** Send 3 DM MWr, 1 beat each, commit bit set, then 3 commits with TC=0. Required: outstanding goes 1,2,3,2,1,0. err_underflow=0.
- **Simultaneous events.** Commit TC=0 in the same cycle as a counted MWr header, with outstanding=2. Required: outstanding stays 2.
- **Fence mid-packet.** Raise fence_req during beat 2 of a 4-beat MWr, with outstanding=1 before that packet.
  - Required: the packet finishes and the next sop is blocked.
  - fence_done pulses 1 cycle after the second commit brings outstanding to 0. fence_busy then drops.
- **Interrupt commit.** Commit with TC[0]=1 and metadata_l=2. Required: intr_ack=4'b0100 for one cycle, outstanding unchanged. With metadata_l=7: no pulse.
- **Saturation and underflow.**
  - CNT_WIDTH=2: after 3 uncommitted writes, the 4th header sees afu_tx_tready=0 until a commit arrives. A non-write packet still passes.
  - Separately, a commit at outstanding=0 sets err_underflow, which stays set until rst.
- **Disabled tracking.** With TUSER_STORE_COMMIT_REQ_BIT=0, writes are never counted and outstanding stays 0.

Source files
------------

// File: rtl/pcie_wr_commit_tracker.sv
// Commit tracker on the AFU TX path: counts committed writes, acknowledges
// interrupt commits and provides a packet-boundary write fence.
module pcie_wr_commit_tracker #(
    parameter int TDATA_WIDTH                = 512,
    parameter int TUSER_WIDTH                = 10,
    parameter int TUSER_STORE_COMMIT_REQ_BIT = 1,
    parameter int CNT_WIDTH                  = 10,
    parameter int NUM_INTR                   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     afu_tx_tvalid,
    output logic                     afu_tx_tready,
    input  logic [TDATA_WIDTH-1:0]   afu_tx_tdata,
    input  logic [TDATA_WIDTH/8-1:0] afu_tx_tkeep,
    input  logic                     afu_tx_tlast,
    input  logic [TUSER_WIDTH-1:0]   afu_tx_tuser_vendor,
    output logic                     fim_tx_tvalid,
    input  logic                     fim_tx_tready,
    output logic [TDATA_WIDTH-1:0]   fim_tx_tdata,
    output logic [TDATA_WIDTH/8-1:0] fim_tx_tkeep,
    output logic                     fim_tx_tlast,
    output logic [TUSER_WIDTH-1:0]   fim_tx_tuser_vendor,
    input  logic                     commit_tvalid,
    output logic                     commit_tready,
    input  logic [TDATA_WIDTH-1:0]   commit_tdata,
    input  logic [TUSER_WIDTH-1:0]   commit_tuser_vendor,
    input  logic                     fence_req,
    output logic                     fence_busy,
    output logic                     fence_done,
    output logic [CNT_WIDTH-1:0]     outstanding,
    output logic [NUM_INTR-1:0]      intr_ack,
    output logic                     err_underflow
);

    localparam logic [7:0] FT_MWR32 = 8'h40;
    localparam logic [7:0] FT_MWR64 = 8'h60;
    localparam logic [7:0] FT_INTR  = 8'h30;
    localparam logic [7:0] FT_CPL   = 8'h0A;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EOP, S_DRAIN} state_e;

    state_e                state_q, state_d;
    logic                  sop_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [NUM_INTR-1:0]   intr_q, intr_d;

    logic [7:0]  hdr_ft, cpl_ft;
    logic [31:0] cpl_meta;
    logic        commit_req, hdr_wr, hdr_intr, allow, acc, inc, dec, cmt_ok, iack;

    // TX header: fmt_type in DW0 byte 3; tuser bit 0 flags data-mover mode
    assign hdr_ft     = afu_tx_tdata[31:24];
    assign commit_req = (TUSER_STORE_COMMIT_REQ_BIT != 0)
                     && afu_tx_tuser_vendor[TUSER_STORE_COMMIT_REQ_BIT];
    assign hdr_wr     = commit_req && (hdr_ft == FT_MWR32 || hdr_ft == FT_MWR64);
    assign hdr_intr   = commit_req && afu_tx_tuser_vendor[0] && (hdr_ft == FT_INTR);

    assign allow = !(sop_q && ((state_q != S_IDLE) || fence_req
                               || (hdr_wr && cnt_q == '1)));

    assign fim_tx_tvalid       = afu_tx_tvalid && allow;
    assign afu_tx_tready       = fim_tx_tready && allow;
    assign fim_tx_tdata        = afu_tx_tdata;
    assign fim_tx_tkeep        = afu_tx_tkeep;
    assign fim_tx_tlast        = afu_tx_tlast;
    assign fim_tx_tuser_vendor = afu_tx_tuser_vendor;

    assign acc = afu_tx_tvalid && afu_tx_tready;
    assign inc = acc && sop_q && hdr_wr;

    // Completion header: TC[0] at bit 20, metadata_l in DW3
    assign cpl_ft   = commit_tdata[31:24];
    assign cpl_meta = commit_tdata[127:96];
    assign cmt_ok   = commit_tvalid && (cpl_ft == FT_CPL);
    assign dec      = cmt_ok && !commit_tdata[20];
    assign iack     = cmt_ok && commit_tdata[20];

    logic unused_ok;
    assign unused_ok = ^{commit_tuser_vendor, commit_tdata[TDATA_WIDTH-1:128],
                         commit_tdata[95:32], commit_tdata[23:21],
                         commit_tdata[19:0], hdr_intr};

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        intr_d = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            intr_d[i] = iack && (cpl_meta == 32'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (fence_req) state_d = sop_q ? S_DRAIN : S_WAIT_EOP;
            S_WAIT_EOP: if (acc && afu_tx_tlast) state_d = S_DRAIN;
            S_DRAIN:    if (cnt_q == '0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fence_busy = (state_q != S_IDLE);
        fence_done = (state_q == S_DRAIN) && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sop_q   <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            intr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (acc) sop_q <= afu_tx_tlast;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            intr_q  <= intr_d;
        end
    end

    assign commit_tready = 1'b1;
    assign outstanding   = cnt_q;
    assign intr_ack      = intr_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_pcie_wr_commit_tracker.sv
// Scoreboard bench for pcie_wr_commit_tracker: one small-counter instance
// plus one instance with commit tracking disabled, sharing the TX stimulus.
module tb_pcie_wr_commit_tracker;

    localparam int TDW = 512;
    localparam int TUW = 10;
    localparam int CW  = 2;
    localparam int NI  = 4;

    localparam logic [7:0] MWR = 8'h60;
    localparam logic [7:0] MRD = 8'h20;
    localparam logic [7:0] CPL = 8'h0A;
    localparam logic [TUW-1:0] U_CMT = TUW'(3);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           afu_tx_tvalid, afu_tx_tlast, fim_tx_tready;
    logic [TDW-1:0] afu_tx_tdata, commit_tdata;
    logic [TDW/8-1:0] afu_tx_tkeep;
    logic [TUW-1:0] afu_tx_tuser_vendor, commit_tuser_vendor;
    logic           commit_tvalid, fence_req;

    logic           afu_tx_tready, fim_tx_tvalid, fim_tx_tlast, commit_tready;
    logic [TDW-1:0] fim_tx_tdata;
    logic [TDW/8-1:0] fim_tx_tkeep;
    logic [TUW-1:0] fim_tx_tuser_vendor;
    logic           fence_busy, fence_done, err_underflow;
    logic [CW-1:0]  outstanding;
    logic [NI-1:0]  intr_ack;

    logic           d_tready, d_tvalid, d_tlast, d_ctready, d_busy, d_done, d_err;
    logic [TDW-1:0] d_tdata;
    logic [TDW/8-1:0] d_tkeep;
    logic [TUW-1:0] d_tuser;
    logic [9:0]     d_out;
    logic [NI-1:0]  d_iack;

    pcie_wr_commit_tracker #(
        .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW),
        .TUSER_STORE_COMMIT_REQ_BIT(1), .CNT_WIDTH(CW), .NUM_INTR(NI)
    ) u_dut (
        .clk(clk), .rst(rst),
        .afu_tx_tvalid(afu_tx_tvalid), .afu_tx_tready(afu_tx_tready),
        .afu_tx_tdata(afu_tx_tdata), .afu_tx_tkeep(afu_tx_tkeep),
        .afu_tx_tlast(afu_tx_tlast), .afu_tx_tuser_vendor(afu_tx_tuser_vendor),
        .fim_tx_tvalid(fim_tx_tvalid), .fim_tx_tready(fim_tx_tready),
        .fim_tx_tdata(fim_tx_tdata), .fim_tx_tkeep(fim_tx_tkeep),
        .fim_tx_tlast(fim_tx_tlast), .fim_tx_tuser_vendor(fim_tx_tuser_vendor),
        .commit_tvalid(commit_tvalid), .commit_tready(commit_tready),
        .commit_tdata(commit_tdata), .commit_tuser_vendor(commit_tuser_vendor),
        .fence_req(fence_req), .fence_busy(fence_busy), .fence_done(fence_done),
        .outstanding(outstanding), .intr_ack(intr_ack),
        .err_underflow(err_underflow)
    );

    pcie_wr_commit_tracker #(
        .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW),
        .TUSER_STORE_COMMIT_REQ_BIT(0), .CNT_WIDTH(10), .NUM_INTR(NI)
    ) u_dis (
        .clk(clk), .rst(rst),
        .afu_tx_tvalid(afu_tx_tvalid), .afu_tx_tready(d_tready),
        .afu_tx_tdata(afu_tx_tdata), .afu_tx_tkeep(afu_tx_tkeep),
        .afu_tx_tlast(afu_tx_tlast), .afu_tx_tuser_vendor(afu_tx_tuser_vendor),
        .fim_tx_tvalid(d_tvalid), .fim_tx_tready(1'b1),
        .fim_tx_tdata(d_tdata), .fim_tx_tkeep(d_tkeep),
        .fim_tx_tlast(d_tlast), .fim_tx_tuser_vendor(d_tuser),
        .commit_tvalid(1'b0), .commit_tready(d_ctready),
        .commit_tdata(commit_tdata), .commit_tuser_vendor(commit_tuser_vendor),
        .fence_req(1'b0), .fence_busy(d_busy), .fence_done(d_done),
        .outstanding(d_out), .intr_ack(d_iack), .err_underflow(d_err)
    );

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return 32'(outstanding);
            1: return 32'(intr_ack);
            2: return 32'(fence_done);
            3: return 32'(fence_busy);
            4: return 32'(err_underflow);
            5: return 32'(d_out);
            default: return 32'hdead;
        endcase
    endfunction

    task automatic expect_nxt(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs(e.sel), 32'(e.val));
        end
    endtask

    function automatic logic [TDW-1:0] hdr(input logic [7:0] ft, input logic [31:0] meta,
                                           input logic [2:0] tc);
        logic [TDW-1:0] d;
        d = '0;
        d[31:24]  = ft;
        d[22:20]  = tc;
        d[127:96] = meta;
        return d;
    endfunction

    task automatic tx(input logic [7:0] ft, input logic last);
        afu_tx_tvalid       = 1'b1;
        afu_tx_tdata        = hdr(ft, 32'd0, 3'd0);
        afu_tx_tuser_vendor = U_CMT;
        afu_tx_tlast        = last;
    endtask

    task automatic tx_off();
        afu_tx_tvalid = 1'b0;
        afu_tx_tlast  = 1'b0;
    endtask

    task automatic cmt(input logic [2:0] tc, input logic [31:0] meta);
        commit_tvalid = 1'b1;
        commit_tdata  = hdr(CPL, meta, tc);
    endtask

    task automatic cmt_off();
        commit_tvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        afu_tx_tvalid = 1'b0;
        afu_tx_tlast = 1'b0;
        afu_tx_tdata = '0;
        afu_tx_tkeep = '1;
        afu_tx_tuser_vendor = '0;
        fim_tx_tready = 1'b0;
        commit_tvalid = 1'b0;
        commit_tdata = '0;
        commit_tuser_vendor = '0;
        fence_req = 1'b0;

        tick();
        tick();
        chk("rst_out", obs(0), 0);
        chk("rst_iack", obs(1), 0);
        chk("rst_done", obs(2), 0);
        chk("rst_busy", obs(3), 0);
        chk("rst_err", obs(4), 0);
        chk("rst_ctready", 32'(commit_tready), 1);
        tx(MWR, 1'b1);
        #1;
        chk("rst_fim_tvalid", 32'(fim_tx_tvalid), 1);
        chk("rst_tready_bp", 32'(afu_tx_tready), 0);
        tx_off();
        rst = 1'b0;
        fim_tx_tready = 1'b1;
        tick();

        // counting: 1,2,3 then 2,1,0
        for (int i = 1; i <= 3; i++) begin
            tx(MWR, 1'b1);
            #1 chk("cnt_tready", 32'(afu_tx_tready), 1);
            expect_nxt("cnt_up", 0, i);
            tick();
        end
        tx_off();
        for (int i = 2; i >= 0; i--) begin
            cmt(3'd0, 32'd0);
            expect_nxt("cnt_dn", 0, i);
            expect_nxt("cnt_err", 4, 0);
            tick();
        end
        cmt_off();
        expect_nxt("dis_cnt", 5, 0);
        tick();

        // simultaneous increment and decrement at 2
        tx(MWR, 1'b1);
        tick();
        tick();
        chk("sim_pre", obs(0), 2);
        cmt(3'd0, 32'd0);
        expect_nxt("sim_hold", 0, 2);
        tick();
        tx_off();
        expect_nxt("sim_dn", 0, 1);
        tick();
        cmt_off();

        // fence raised mid-packet with one write outstanding
        tx(MWR, 1'b0);
        expect_nxt("fen_sop", 0, 2);
        tick();
        fence_req = 1'b1;
        tx(MWR, 1'b0);
        #1 chk("fen_b2_rdy", 32'(afu_tx_tready), 1);
        expect_nxt("fen_busy", 3, 1);
        tick();
        tx(MWR, 1'b0);
        #1 chk("fen_b3_rdy", 32'(afu_tx_tready), 1);
        tick();
        tx(MWR, 1'b1);
        #1 chk("fen_b4_rdy", 32'(afu_tx_tready), 1);
        tick();
        tx(MWR, 1'b1);
        #1 chk("fen_sop_blk", 32'(afu_tx_tready), 0);
        cmt(3'd0, 32'd0);
        expect_nxt("fen_c1", 0, 1);
        expect_nxt("fen_nodone", 2, 0);
        tick();
        expect_nxt("fen_c2", 0, 0);
        expect_nxt("fen_done", 2, 1);
        expect_nxt("fen_busy2", 3, 1);
        tick();
        cmt_off();
        fence_req = 1'b0;
        chk("fen_still_blk", 32'(afu_tx_tready), 0);
        expect_nxt("fen_idle", 3, 0);
        expect_nxt("fen_done_end", 2, 0);
        expect_nxt("fen_no_acc", 0, 0);
        tick();
        chk("fen_release", 32'(afu_tx_tready), 1);
        expect_nxt("fen_acc", 0, 1);
        tick();
        tx_off();
        cmt(3'd0, 32'd0);
        expect_nxt("fen_clear", 0, 0);
        tick();

        // interrupt commits
        cmt(3'd1, 32'd2);
        expect_nxt("iack2", 1, 4);
        expect_nxt("iack_cnt", 0, 0);
        tick();
        cmt_off();
        expect_nxt("iack_pulse", 1, 0);
        tick();
        cmt(3'd1, 32'd7);
        expect_nxt("iack7", 1, 0);
        expect_nxt("iack7_err", 4, 0);
        tick();
        cmt_off();

        // saturation with a 2-bit counter
        for (int i = 1; i <= 3; i++) begin
            tx(MWR, 1'b1);
            expect_nxt("sat_up", 0, i);
            tick();
        end
        tx(MWR, 1'b1);
        #1 chk("sat_blk", 32'(afu_tx_tready), 0);
        chk("sat_fim_v", 32'(fim_tx_tvalid), 0);
        expect_nxt("sat_hold", 0, 3);
        tick();
        tx(MRD, 1'b1);
        #1 chk("sat_rd_pass", 32'(afu_tx_tready), 1);
        expect_nxt("sat_rd_cnt", 0, 3);
        tick();
        tx(MWR, 1'b1);
        cmt(3'd0, 32'd0);
        #1 chk("sat_blk2", 32'(afu_tx_tready), 0);
        expect_nxt("sat_cmt", 0, 2);
        tick();
        cmt_off();
        chk("sat_unblk", 32'(afu_tx_tready), 1);
        expect_nxt("sat_refill", 0, 3);
        tick();
        tx_off();
        for (int i = 2; i >= 0; i--) begin
            cmt(3'd0, 32'd0);
            expect_nxt("sat_dn", 0, i);
            tick();
        end
        expect_nxt("dis_cnt2", 5, 0);

        // underflow is sticky until reset
        expect_nxt("uf_set", 4, 1);
        expect_nxt("uf_cnt", 0, 0);
        tick();
        cmt_off();
        expect_nxt("uf_sticky", 4, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("uf_rst", obs(4), 0);
        chk("dis_final", obs(5), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
